iob_reset_seq: RTL and testbench

//   Power-on/soft reset sequencer driving N_DOM reset-synchronizer-backed domains.

---
 rtl/iob_reset_seq.sv | 166 ++++++++++++++++
 tb/tb_iob_reset_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/iob_reset_seq.sv
// Reset sequencer: holds all domain resets, then releases them in index order, gated by ready_i.
// Optional ready-wait timeout with retry is compiled in by defining IOB_RESET_SEQ_TIMEOUT_EN.
module iob_reset_seq #(
  parameter int unsigned N_DOM    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned STEP_CYC = 4,
  parameter int unsigned TOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cke_i,
  input  logic             req_i,
  output logic             ack_o,
  input  logic [N_DOM-1:0] ready_i,
  output logic [N_DOM-1:0] rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned RelW = $clog2(N_DOM + 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] StepLast = CNT_W'(STEP_CYC - 1);
  localparam logic [RelW-1:0]  RelAll   = RelW'(N_DOM);

  typedef enum logic [1:0] {StAssert, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RelW-1:0]  rel_cnt_q, rel_cnt_d;
  logic [N_DOM-1:0] rst_q, rst_d;
  logic             ack_q, ack_d;
  logic             ready_sel;
  logic             timeout_hit;

  // Only the most recently released domain's ready flag matters.
  always_comb begin
    ready_sel = 1'b0;
    for (int k = 0; k < N_DOM; k++) begin
      if (rel_cnt_q == RelW'(k + 1)) ready_sel = ready_i[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rel_cnt_d = rel_cnt_q;
    ack_d     = 1'b0;
    unique case (state_q)
      StAssert: begin
        if (req_i) begin
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          rel_cnt_d = RelW'(1);
          cnt_d     = '0;
          state_d   = StWait;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWait: begin
        if (req_i) begin
          state_d   = StAssert;
          cnt_d     = '0;
          rel_cnt_d = '0;
          ack_d     = 1'b1;
        end else if (cnt_q == StepLast) begin
          if (ready_sel) begin
            if (rel_cnt_q == RelAll) begin
              state_d = StDone;
            end else begin
              rel_cnt_d = rel_cnt_q + RelW'(1);
              cnt_d     = '0;
            end
          end else if (timeout_hit) begin
            state_d   = StAssert;
            cnt_d     = '0;
            rel_cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (req_i) begin
          state_d   = StAssert;
          cnt_d     = '0;
          rel_cnt_d = '0;
          ack_d     = 1'b1;
        end
      end
      default: begin
        state_d   = StAssert;
        cnt_d     = '0;
        rel_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    rst_d = '0;
    for (int k = 0; k < N_DOM; k++) begin
      rst_d[k] = (RelW'(k) >= rel_cnt_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StAssert;
      cnt_q     <= '0;
      rel_cnt_q <= '0;
      rst_q     <= '1;
      ack_q     <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rel_cnt_q <= rel_cnt_d;
      rst_q     <= rst_d;
      ack_q     <= ack_d;
    end
  end

`ifdef IOB_RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ToutLast = CNT_W'(TOUT_CYC - 1);

  logic [CNT_W-1:0] tout_q, tout_d;
  logic             err_q;
  logic             stalled;

  assign stalled     = (state_q == StWait) && (cnt_q == StepLast) && !ready_sel;
  assign timeout_hit = stalled && (tout_q == ToutLast);

  // Any change of rel_cnt is a release, a WAIT entry or a restart; all clear the timer.
  always_comb begin
    tout_d = tout_q;
    if (rel_cnt_d != rel_cnt_q) begin
      tout_d = '0;
    end else if (stalled) begin
      tout_d = tout_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tout_q <= '0;
      err_q  <= 1'b0;
    end else if (cke_i) begin
      tout_q <= tout_d;
      if (timeout_hit && !req_i) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_hit = 1'b0;
  // TOUT_CYC is at least 1, so this ties err_o low.
  assign err_o = (TOUT_CYC == 0);
`endif

  assign rst_o  = rst_q;
  assign ack_o  = ack_q;
  assign busy_o = (state_q != StDone);
  assign done_o = (state_q == StDone);

endmodule

// File: tb/tb_iob_reset_seq.sv
// Self-checking bench for iob_reset_seq: directed release timeline, then randomized
// reset/enable/request/ready stimulus against a behavioural phase model.
module tb_iob_reset_seq;

  localparam int unsigned N_DOM    = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned HOLD_CYC = 16;
  localparam int unsigned STEP_CYC = 4;
  localparam int unsigned TOUT_CYC = 64;

  logic             clk = 1'b0;
  logic             rst_i, cke_i, req_i;
  logic [N_DOM-1:0] ready_i;
  logic             ack_o, busy_o, done_o, err_o;
  logic [N_DOM-1:0] rst_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = holding, 1 = releasing, 2 = all released.
  int m_phase, m_held, m_age, m_rel, m_stall;
  bit m_ack, m_err;

  iob_reset_seq #(
    .N_DOM    (N_DOM),
    .CNT_W    (CNT_W),
    .HOLD_CYC (HOLD_CYC),
    .STEP_CYC (STEP_CYC),
    .TOUT_CYC (TOUT_CYC)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .cke_i   (cke_i),
    .req_i   (req_i),
    .ack_o   (ack_o),
    .ready_i (ready_i),
    .rst_o   (rst_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_restart();
    m_phase = 0;
    m_held  = 0;
    m_rel   = 0;
  endtask

  task automatic model_edge(input bit r, input bit ce, input bit rq, input logic [N_DOM-1:0] rdy);
    if (r) begin
      model_restart();
      m_ack   = 0;
      m_err   = 0;
      m_stall = 0;
    end else if (ce) begin
      m_ack = 0;
      if (m_phase == 0) begin
        if (rq) begin
          m_held = 0;
        end else begin
          m_held++;
          if (m_held == HOLD_CYC) begin
            m_phase = 1;
            m_rel   = 1;
            m_age   = 0;
            m_stall = 0;
          end
        end
      end else if (rq) begin
        model_restart();
        m_ack = 1;
      end else if (m_phase == 1) begin
        m_age++;
        if (m_age >= STEP_CYC) begin
          if (rdy[m_rel-1]) begin
            if (m_rel == N_DOM) begin
              m_phase = 2;
            end else begin
              m_rel++;
              m_age   = 0;
              m_stall = 0;
            end
          end else begin
`ifdef IOB_RESET_SEQ_TIMEOUT_EN
            m_stall++;
            if (m_stall == TOUT_CYC) begin
              m_err = 1;
              model_restart();
            end
`endif
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N_DOM-1:0] exp_rst;
    exp_rst = '1;
    exp_rst = exp_rst << m_rel;
    check_eq("rst_o", 32'(rst_o), 32'(exp_rst));
    check_eq("busy_o", 32'(busy_o), 32'(m_phase != 2));
    check_eq("done_o", 32'(done_o), 32'(m_phase == 2));
    check_eq("ack_o", 32'(ack_o), 32'(m_ack));
    check_eq("err_o", 32'(err_o), 32'(m_err));
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic run_cycle(input bit r, input bit ce, input bit rq, input logic [N_DOM-1:0] rdy);
    rst_i   = r;
    cke_i   = ce;
    req_i   = rq;
    ready_i = rdy;
    @(posedge clk);
    model_edge(r, ce, rq, rdy);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int req_hold;
    logic [N_DOM-1:0] rdy;
    rst_i   = 1'b1;
    cke_i   = 1'b1;
    req_i   = 1'b0;
    ready_i = '1;
    m_ack   = 0;
    m_err   = 0;
    m_stall = 0;
    model_restart();
    @(negedge clk);
    run_cycle(1, 1, 0, '1);
    run_cycle(1, 1, 0, '1);
    check_eq("reset_rst", 32'(rst_o), 32'hF);
    check_eq("reset_busy", 32'(busy_o), 32'd1);
    check_eq("reset_done", 32'(done_o), 32'd0);

    // Release timeline with every domain ready.
    for (int n = 1; n <= 40; n++) begin
      run_cycle(0, 1, 0, '1);
      if (n == 15) check_eq("t15_rst", 32'(rst_o), 32'hF);
      if (n == 16) check_eq("t16_rst", 32'(rst_o), 32'hE);
      if (n == 19) check_eq("t19_rst", 32'(rst_o), 32'hE);
      if (n == 20) check_eq("t20_rst", 32'(rst_o), 32'hC);
      if (n == 24) check_eq("t24_rst", 32'(rst_o), 32'h8);
      if (n == 28) check_eq("t28_rst", 32'(rst_o), 32'h0);
      if (n == 31) check_eq("t31_done", 32'(done_o), 32'd0);
      if (n == 32) check_eq("t32_done", 32'(done_o), 32'd1);
    end

    // Soft request from DONE: one ack, resets reasserted.
    run_cycle(0, 1, 1, '1);
    check_eq("req_ack", 32'(ack_o), 32'd1);
    check_eq("req_rst", 32'(rst_o), 32'hF);
    run_cycle(0, 1, 0, '1);
    check_eq("req_ack_end", 32'(ack_o), 32'd0);

    // Randomized phase.
    req_hold = 0;
    rdy      = '1;
    for (int i = 0; i < 4000; i++) begin
      bit r, ce;
      r  = ($urandom_range(0, 299) == 0);
      ce = ($urandom_range(0, 7) != 0);
      if (req_hold > 0) req_hold--;
      else if ($urandom_range(0, 59) == 0) req_hold = $urandom_range(1, 10);
      if ($urandom_range(0, 5) == 0) rdy = N_DOM'($urandom | $urandom);
      run_cycle(r, ce, req_hold > 0, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
